// File: rtl/debug_trace_transmitter.sv
// Debug trace transmitter: snapshots processor debug state into a FIFO and shifts each word out MSB-first.
// Optional build macro TRACE_PARITY_EN appends an even-parity bit to every frame.
module debug_trace_transmitter #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       pc,
    input  logic [7:0]       ir,
    input  logic [7:0]       pm_data,
    input  logic [3:0]       o_reg,
    input  logic             zero_flag,
    input  logic             capture_en,
    input  logic             tx_ready,
    output logic             tx_data,
    output logic             tx_valid,
    output logic             tx_frame,
    output logic             fifo_full,
    output logic             overflow,
    output logic [CNT_W-1:0] dropped_count
);

    // state | meaning
    // IDLE  | no frame in flight; load the FIFO head when one is available
    // SHIFT | driving the 32 data bits, MSB first
    // PAR   | driving the even-parity bit (TRACE_PARITY_EN builds only)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef TRACE_PARITY_EN
    localparam logic [1:0] ST_PAR   = 2'd2;
`endif

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [1:0]    state;
    logic [31:0]   shreg;
    logic [4:0]    bit_cnt;
    logic [31:0]   snapshot;
    logic          push_ok;
    logic          pop;
`ifdef TRACE_PARITY_EN
    logic          par_bit;
`endif

    assign snapshot  = {pc, ir, pm_data, o_reg, zero_flag, 3'b000};
    // Fullness is judged on the count at the start of the cycle, so a same-cycle pop never rescues a push.
    assign push_ok   = capture_en && (count < DEPTH_C);
    assign pop       = (state == ST_IDLE) && (count != '0);
    assign fifo_full = (count == DEPTH_C);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= snapshot;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            overflow      <= 1'b0;
            dropped_count <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + (PW+1)'(push_ok) - (PW+1)'(pop);
            if (capture_en && !push_ok) begin
                overflow <= 1'b1;
                if (dropped_count != '1) begin
                    dropped_count <= dropped_count + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
`ifdef TRACE_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (count != '0) begin
                        shreg   <= mem[rd_ptr];
                        bit_cnt <= '0;
`ifdef TRACE_PARITY_EN
                        par_bit <= ^mem[rd_ptr];
`endif
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (tx_ready) begin
                        shreg   <= {shreg[30:0], 1'b0};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd31) begin
`ifdef TRACE_PARITY_EN
                            state <= ST_PAR;
`else
                            state <= ST_IDLE;
`endif
                        end
                    end
                end
`ifdef TRACE_PARITY_EN
                ST_PAR: begin
                    if (tx_ready) begin
                        state <= ST_IDLE;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 1'b0;
        tx_frame = 1'b0;
        case (state)
            ST_SHIFT: begin
                tx_valid = 1'b1;
                tx_data  = shreg[31];
                tx_frame = (bit_cnt == 5'd0);
            end
`ifdef TRACE_PARITY_EN
            ST_PAR: begin
                tx_valid = 1'b1;
                tx_data  = par_bit;
            end
`endif
            default: begin
                tx_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_debug_trace_transmitter.sv
// Directed bench for debug_trace_transmitter; honours TRACE_PARITY_EN for the parity-bit checks.
module tb_debug_trace_transmitter;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pc, ir, pm_data;
    logic [3:0] o_reg;
    logic       zero_flag, capture_en, tx_ready;
    logic       tx_data, tx_valid, tx_frame, fifo_full, overflow;
    logic [7:0] dropped_count;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] FRAME_A = 32'h12345678;  // 13 ones -> parity 1
    localparam logic [31:0] FRAME_B = 32'hA53C0F90;  // 14 ones -> parity 0

    debug_trace_transmitter #(.DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .pc(pc), .ir(ir), .pm_data(pm_data),
        .o_reg(o_reg), .zero_flag(zero_flag), .capture_en(capture_en),
        .tx_ready(tx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_frame(tx_frame), .fifo_full(fifo_full), .overflow(overflow),
        .dropped_count(dropped_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a();
        pc = 8'h12; ir = 8'h34; pm_data = 8'h56; o_reg = 4'h7; zero_flag = 1'b1;
    endtask

    task automatic set_b();
        pc = 8'hA5; ir = 8'h3C; pm_data = 8'h0F; o_reg = 4'h9; zero_flag = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; capture_en = 1'b0; tx_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    // Collects one 32-bit frame; stalls tx_ready for stall_len cycles at bit index stall_at.
    task automatic recv_frame(input int stall_at, input int stall_len,
                              output logic [31:0] got, output int frame_err,
                              output int hold_err, output int timeout);
        int w;
        got = '0; frame_err = 0; hold_err = 0; timeout = 0; w = 0;
        tx_ready = 1'b1;
        while (tx_valid !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        if (tx_valid !== 1'b1) begin
            timeout = 1;
            return;
        end
        for (int i = 0; i < 32; i++) begin
            got[31-i] = tx_data;
            if (tx_valid !== 1'b1 || tx_frame !== (i == 0)) frame_err++;
            if (i == stall_at) begin
                tx_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    if (tx_data !== got[31-i] || tx_valid !== 1'b1 || tx_frame !== (i == 0))
                        hold_err++;
                end
                tx_ready = 1'b1;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; capture_en = 1'b0; tx_ready = 1'b0;
        set_a();
        repeat (3) tick();
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid); end
        total++; if (tx_data !== 1'b0) begin bad++; $display("FAIL reset_tx_data got=%b want=0", tx_data); end
        total++; if (tx_frame !== 1'b0) begin bad++; $display("FAIL reset_tx_frame got=%b want=0", tx_frame); end
        total++; if (fifo_full !== 1'b0) begin bad++; $display("FAIL reset_fifo_full got=%b want=0", fifo_full); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
        total++; if (dropped_count !== 8'd0) begin bad++; $display("FAIL reset_dropped got=%0d want=0", dropped_count); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_frame();
        logic [31:0] got;
        int fe, he, to;
        do_reset();
        set_a();
        tx_ready = 1'b1;
        capture_en = 1'b1;
        tick();
        capture_en = 1'b0;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL latency_valid_early got=%b want=0", tx_valid); end
        tick();
        total++; if (tx_valid !== 1'b1 || tx_frame !== 1'b1) begin
            bad++; $display("FAIL latency_first_bit got=%b/%b want=1/1", tx_valid, tx_frame); end
        recv_frame(-1, 0, got, fe, he, to);
        total++; if (to != 0) begin bad++; $display("FAIL basic_timeout got=%0d want=0", to); end
        total++; if (got !== FRAME_A) begin bad++; $display("FAIL basic_data got=%h want=%h", got, FRAME_A); end
        total++; if (fe != 0) begin bad++; $display("FAIL basic_frame_flag got=%0d errors want=0", fe); end
`ifdef TRACE_PARITY_EN
        total++; if (tx_valid !== 1'b1 || tx_data !== 1'b1 || tx_frame !== 1'b0) begin
            bad++; $display("FAIL parity_bit got=%b/%b/%b want=1/1/0", tx_valid, tx_data, tx_frame); end
        tick();
`endif
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL basic_end_valid got=%b want=0", tx_valid); end
    endtask

    task automatic test_stall();
        logic [31:0] got;
        int fe, he, to;
        do_reset();
        set_a();
        capture_en = 1'b1;
        tick();
        capture_en = 1'b0;
        recv_frame(10, 5, got, fe, he, to);
        total++; if (got !== FRAME_A || to != 0) begin
            bad++; $display("FAIL stall_data got=%h want=%h", got, FRAME_A); end
        total++; if (he != 0) begin bad++; $display("FAIL stall_hold got=%0d errors want=0", he); end
        total++; if (fe != 0) begin bad++; $display("FAIL stall_frame_flag got=%0d errors want=0", fe); end
    endtask

    task automatic test_overflow();
        do_reset();
        set_a();
        tx_ready = 1'b0;
        capture_en = 1'b1;
        repeat (10) tick();
        capture_en = 1'b0;
        total++; if (fifo_full !== 1'b1) begin bad++; $display("FAIL ovf_full got=%b want=1", fifo_full); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", overflow); end
        total++; if (dropped_count !== 8'd5) begin bad++; $display("FAIL ovf_dropped got=%0d want=5", dropped_count); end
        total++; if (tx_valid !== 1'b1 || tx_frame !== 1'b1) begin
            bad++; $display("FAIL ovf_holding got=%b/%b want=1/1", tx_valid, tx_frame); end
        tx_ready = 1'b1;
        repeat (40) tick();
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] got;
        int fe, he, to;
        int seen;
        do_reset();
        set_a();
        tx_ready = 1'b1;
        capture_en = 1'b1;
        repeat (2) tick();
        capture_en = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", tx_valid); end
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (tx_valid === 1'b1) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL midrst_fifo_empty got=%0d valid cycles want=0", seen); end
        set_b();
        capture_en = 1'b1;
        tick();
        capture_en = 1'b0;
        recv_frame(-1, 0, got, fe, he, to);
        total++; if (got !== FRAME_B || to != 0) begin
            bad++; $display("FAIL midrst_fresh_data got=%h want=%h", got, FRAME_B); end
        total++; if (fe != 0) begin bad++; $display("FAIL midrst_frame_flag got=%0d errors want=0", fe); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got;
        int fe, he, to;
        do_reset();
        tx_ready = 1'b1;
        set_a();
        capture_en = 1'b1;
        tick();
        set_b();
        tick();
        capture_en = 1'b0;
        recv_frame(-1, 0, got, fe, he, to);
        total++; if (got !== FRAME_A || fe != 0 || to != 0) begin
            bad++; $display("FAIL b2b_first got=%h want=%h", got, FRAME_A); end
`ifdef TRACE_PARITY_EN
        total++; if (tx_valid !== 1'b1 || tx_data !== 1'b1) begin
            bad++; $display("FAIL b2b_parity_a got=%b/%b want=1/1", tx_valid, tx_data); end
        tick();
`endif
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL b2b_bubble got=%b want=0", tx_valid); end
        tick();
        total++; if (tx_valid !== 1'b1 || tx_frame !== 1'b1) begin
            bad++; $display("FAIL b2b_second_start got=%b/%b want=1/1", tx_valid, tx_frame); end
        recv_frame(-1, 0, got, fe, he, to);
        total++; if (got !== FRAME_B || fe != 0 || to != 0) begin
            bad++; $display("FAIL b2b_second got=%h want=%h", got, FRAME_B); end
`ifdef TRACE_PARITY_EN
        total++; if (tx_valid !== 1'b1 || tx_data !== 1'b0) begin
            bad++; $display("FAIL b2b_parity_b got=%b/%b want=1/0", tx_valid, tx_data); end
        tick();
`endif
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b want=0", tx_valid); end
    endtask

    initial begin
        reset = 1'b1; capture_en = 1'b0; tx_ready = 1'b0;
        set_a();
        test_reset();
        test_basic_frame();
        test_stall();
        test_overflow();
        test_reset_midframe();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
